// File: rtl/fb_pkg.sv
// Shared frame-buffer geometry defaults and the bank-state encoding.
package fb_pkg;

    localparam int unsigned FB_OUT_WIDTH  = 320;
    localparam int unsigned FB_OUT_HEIGHT = 240;
    localparam int unsigned FB_FRAME_SIZE = FB_OUT_WIDTH * FB_OUT_HEIGHT;
    localparam int unsigned FB_PIXEL_BITS = 12;
    localparam int unsigned FB_ADDR_WIDTH = 17;

    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_PENDING = 2'd1,
        BANK_SHOWING = 2'd2
    } bank_state_t;

endpackage

// File: rtl/fb_bank_ctrl.sv
// Double-buffer bank controller: tracks writer/reader frame handoff,
// swaps banks on reader vsync and counts frames overwritten before display.
module fb_bank_ctrl
    import fb_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_frame_done,
    input  logic       i_rd_frame_start,
    output logic       o_wr_bank,
    output logic       o_rd_bank,
    output logic       o_frame_ready,
    output logic [7:0] o_drop_count
);

    bank_state_t r_state;
    bank_state_t w_state_nxt;
    logic        w_swap;
    logic        w_drop;
    logic        r_wr_bank;
    logic        r_frame_ready;
    logic [7:0]  r_drop_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= BANK_EMPTY;
            r_wr_bank     <= 1'b0;
            r_frame_ready <= 1'b0;
            r_drop_count  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_swap) begin
                r_wr_bank     <= ~r_wr_bank;
                r_frame_ready <= 1'b1;
            end
            if (w_drop && (r_drop_count != 8'hFF)) begin
                r_drop_count <= r_drop_count + 8'd1;
            end
        end
    end

    // A pending frame that gets overwritten before the reader takes it is a drop,
    // even when the reader takes the newer one in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_swap      = 1'b0;
        w_drop      = 1'b0;
        case (r_state)
            BANK_PENDING: begin
                w_drop = i_frame_done;
                if (i_rd_frame_start) begin
                    w_swap      = 1'b1;
                    w_state_nxt = BANK_SHOWING;
                end
            end
            default: begin
                if (i_frame_done) begin
                    w_state_nxt = BANK_PENDING;
                end
            end
        endcase
    end

    assign o_wr_bank     = r_wr_bank;
    assign o_rd_bank     = ~r_wr_bank;
    assign o_frame_ready = r_frame_ready;
    assign o_drop_count  = r_drop_count;

endmodule

// File: rtl/fb_port_arbiter.sv
// Single-port frame-buffer arbiter: read-priority grant with write
// starvation guard, registered memory command and fixed-latency read return.
module fb_port_arbiter
    import fb_pkg::*;
#(
    parameter int unsigned OUT_WIDTH   = FB_OUT_WIDTH,
    parameter int unsigned OUT_HEIGHT  = FB_OUT_HEIGHT,
    parameter int unsigned PIXEL_BITS  = FB_PIXEL_BITS,
    parameter int unsigned ADDR_WIDTH  = FB_ADDR_WIDTH,
    parameter int unsigned MAX_WR_WAIT = 4
)(
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_wr_req,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [PIXEL_BITS-1:0] i_wr_data,
    output logic                  o_wr_ack,
    input  logic                  i_rd_req,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic                  o_rd_ack,
    output logic                  o_rd_valid,
    output logic [PIXEL_BITS-1:0] o_rd_data,
    input  logic                  i_frame_done,
    input  logic                  i_rd_frame_start,
    output logic                  o_mem_en,
    output logic                  o_mem_we,
    output logic [ADDR_WIDTH:0]   o_mem_addr,
    output logic [PIXEL_BITS-1:0] o_mem_wdata,
    input  logic [PIXEL_BITS-1:0] i_mem_rdata,
    output logic                  o_wr_bank,
    output logic                  o_rd_bank,
    output logic                  o_frame_ready,
    output logic [7:0]            o_drop_count
);

    localparam int unsigned FRAME_SIZE = OUT_WIDTH * OUT_HEIGHT;
    localparam int unsigned AW1        = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH:0] FRAME_LIM = AW1'(FRAME_SIZE);
    localparam int unsigned WAIT_W     = (MAX_WR_WAIT < 1) ? 1 : $clog2(MAX_WR_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WR_WAIT);

    logic                  w_wr_bank;
    logic                  w_rd_bank;
    logic                  w_frame_ready;
    logic [WAIT_W-1:0]     r_wait;
    logic                  w_wr_force;
    logic                  w_wr_grant;
    logic                  w_rd_grant;
    logic                  w_wr_oob;
    logic                  w_rd_oob;
    logic                  r_rd_v1;
    logic                  r_rd_z1;
    logic                  r_rd_v2;
    logic                  r_rd_z2;
    logic                  r_rd_valid;
    logic [PIXEL_BITS-1:0] r_rd_data;
    logic                  r_mem_en;
    logic                  r_mem_we;
    logic [ADDR_WIDTH:0]   r_mem_addr;
    logic [PIXEL_BITS-1:0] r_mem_wdata;

    fb_bank_ctrl u_bank (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .i_frame_done     (i_frame_done),
        .i_rd_frame_start (i_rd_frame_start),
        .o_wr_bank        (w_wr_bank),
        .o_rd_bank        (w_rd_bank),
        .o_frame_ready    (w_frame_ready),
        .o_drop_count     (o_drop_count)
    );

    always_comb begin
        w_wr_force = i_wr_req && (r_wait == WAIT_MAX);
        w_rd_grant = !i_rst && i_rd_req && !w_wr_force;
        w_wr_grant = !i_rst && i_wr_req && (!i_rd_req || w_wr_force);
        w_wr_oob   = {1'b0, i_wr_addr} >= FRAME_LIM;
        w_rd_oob   = {1'b0, i_rd_addr} >= FRAME_LIM;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wait <= '0;
        end else if (!i_wr_req || w_wr_grant) begin
            r_wait <= '0;
        end else if (r_wait != WAIT_MAX) begin
            r_wait <= r_wait + WAIT_W'(1);
        end
    end

    // Out-of-range writes are acknowledged but never reach the memory.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_mem_en <= w_rd_grant || (w_wr_grant && !w_wr_oob);
            r_mem_we <= w_wr_grant && !w_wr_oob;
            if (w_wr_grant) begin
                r_mem_addr  <= {w_wr_bank, i_wr_addr};
                r_mem_wdata <= i_wr_data;
            end else if (w_rd_grant) begin
                r_mem_addr <= {w_rd_bank, i_rd_addr};
            end
        end
    end

    // The zero flag travels with each read so blanking is decided at grant time.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rd_v1    <= 1'b0;
            r_rd_z1    <= 1'b0;
            r_rd_v2    <= 1'b0;
            r_rd_z2    <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_v1    <= w_rd_grant;
            r_rd_z1    <= w_rd_oob || !w_frame_ready;
            r_rd_v2    <= r_rd_v1;
            r_rd_z2    <= r_rd_z1;
            r_rd_valid <= r_rd_v2;
            if (r_rd_v2) begin
                r_rd_data <= r_rd_z2 ? '0 : i_mem_rdata;
            end
        end
    end

    assign o_wr_ack      = w_wr_grant;
    assign o_rd_ack      = w_rd_grant;
    assign o_rd_valid    = r_rd_valid;
    assign o_rd_data     = r_rd_data;
    assign o_mem_en      = r_mem_en;
    assign o_mem_we      = r_mem_we;
    assign o_mem_addr    = r_mem_addr;
    assign o_mem_wdata   = r_mem_wdata;
    assign o_wr_bank     = w_wr_bank;
    assign o_rd_bank     = w_rd_bank;
    assign o_frame_ready = w_frame_ready;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Bench for fb_port_arbiter: cycle-level reference model checked every cycle
// plus directed scenarios with literal expectations.
module tb_fb_port_arbiter;

    localparam int unsigned AW   = 17;
    localparam int unsigned PB   = 12;
    localparam int unsigned MAXW = 4;
    localparam int unsigned FSZ  = 320 * 240;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_req = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [PB-1:0] wr_data = '0;
    logic          wr_ack;
    logic          rd_req = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic          rd_ack;
    logic          rd_valid;
    logic [PB-1:0] rd_data;
    logic          frame_done = 1'b0;
    logic          rd_frame_start = 1'b0;
    logic          mem_en;
    logic          mem_we;
    logic [AW:0]   mem_addr;
    logic [PB-1:0] mem_wdata;
    logic [PB-1:0] mem_rdata = '0;
    logic          wr_bank;
    logic          rd_bank;
    logic          frame_ready;
    logic [7:0]    drop_count;

    int errors = 0;
    int checks = 0;

    fb_port_arbiter #(
        .OUT_WIDTH   (320),
        .OUT_HEIGHT  (240),
        .PIXEL_BITS  (PB),
        .ADDR_WIDTH  (AW),
        .MAX_WR_WAIT (MAXW)
    ) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_wr_req         (wr_req),
        .i_wr_addr        (wr_addr),
        .i_wr_data        (wr_data),
        .o_wr_ack         (wr_ack),
        .i_rd_req         (rd_req),
        .i_rd_addr        (rd_addr),
        .o_rd_ack         (rd_ack),
        .o_rd_valid       (rd_valid),
        .o_rd_data        (rd_data),
        .i_frame_done     (frame_done),
        .i_rd_frame_start (rd_frame_start),
        .o_mem_en         (mem_en),
        .o_mem_we         (mem_we),
        .o_mem_addr       (mem_addr),
        .o_mem_wdata      (mem_wdata),
        .i_mem_rdata      (mem_rdata),
        .o_wr_bank        (wr_bank),
        .o_rd_bank        (rd_bank),
        .o_frame_ready    (frame_ready),
        .o_drop_count     (drop_count)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model state (frame handoff expressed as empty/pending/showing).
    int          m_state   = 0;
    bit          m_wr_bank = 1'b0;
    bit          m_rd_bank = 1'b1;
    bit          m_ready   = 1'b0;
    int          m_drops   = 0;
    int          m_wait    = 0;
    int          cyc       = 0;
    bit          e_en      = 1'b0;
    bit          e_we      = 1'b0;
    logic [AW:0] e_addr    = '0;
    logic [PB-1:0] e_wdata = '0;
    bit          s_v [8];
    bit          s_z [8];
    logic [PB-1:0] s_d [8];

    function automatic void model_reset();
        m_state   = 0;
        m_wr_bank = 1'b0;
        m_rd_bank = 1'b1;
        m_ready   = 1'b0;
        m_drops   = 0;
        m_wait    = 0;
        e_en      = 1'b0;
        e_we      = 1'b0;
        e_addr    = '0;
        e_wdata   = '0;
        for (int i = 0; i < 8; i++) begin
            s_v[i] = 1'b0;
            s_z[i] = 1'b0;
            s_d[i] = '0;
        end
    endfunction

    always @(negedge clk) begin
        bit rg;
        bit wg;
        bit tmp;
        int slot;
        int nxt;
        if (rst) model_reset();
        check("wr_bank", wr_bank, m_wr_bank);
        check("rd_bank", rd_bank, m_rd_bank);
        check("frame_ready", frame_ready, m_ready);
        check("drop_count", drop_count, m_drops);
        check("mem_en", mem_en, e_en);
        check("mem_we", mem_we, e_we);
        if (e_en) check("mem_addr", mem_addr, e_addr);
        if (e_we) check("mem_wdata", mem_wdata, e_wdata);
        slot = cyc % 8;
        check("rd_valid", rd_valid, s_v[slot]);
        if (s_v[slot]) check("rd_data", rd_data, s_d[slot]);
        if (rst) begin
            check("rst_mem_addr", mem_addr, 0);
            check("rst_mem_wdata", mem_wdata, 0);
            check("rst_rd_data", rd_data, 0);
        end
        s_v[slot] = 1'b0;
        nxt = (cyc + 1) % 8;
        if (s_v[nxt] && !s_z[nxt]) s_d[nxt] = mem_rdata;

        rg = !rst && rd_req && !(wr_req && m_wait == MAXW);
        wg = !rst && wr_req && !rg;
        check("rd_ack", rd_ack, rg);
        check("wr_ack", wr_ack, wg);
        if (rd_ack && wr_ack) check("one_grant", 1, 0);

        if (!rst) begin
            e_en = rg || (wg && wr_addr < FSZ);
            e_we = wg && wr_addr < FSZ;
            if (wg) begin
                e_addr  = {m_wr_bank, wr_addr};
                e_wdata = wr_data;
            end else if (rg) begin
                e_addr = {m_rd_bank, rd_addr};
            end
            if (rg) begin
                s_v[(cyc + 3) % 8] = 1'b1;
                s_z[(cyc + 3) % 8] = (rd_addr >= FSZ) || !m_ready;
                s_d[(cyc + 3) % 8] = '0;
            end
            if (!wr_req || wg) m_wait = 0;
            else if (m_wait < MAXW) m_wait = m_wait + 1;
            if (m_state == 1) begin
                if (frame_done && m_drops < 255) m_drops = m_drops + 1;
                if (rd_frame_start) begin
                    tmp       = m_wr_bank;
                    m_wr_bank = m_rd_bank;
                    m_rd_bank = tmp;
                    m_ready   = 1'b1;
                    m_state   = 2;
                end
            end else if (frame_done) begin
                m_state = 1;
            end
        end
        cyc++;
    end

    task automatic drive(input bit rd, input int ra, input bit wr, input int wa,
                         input int wd, input bit fd, input bit fs);
        rd_req         = rd;
        rd_addr        = AW'(ra);
        wr_req         = wr;
        wr_addr        = AW'(wa);
        wr_data        = PB'(wd);
        frame_done     = fd;
        rd_frame_start = fs;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0);
            tick();
        end
    endtask

    task automatic status(input string tag, input bit wb, input bit rb, input bit rdy, input int dc);
        check({tag, "_wr_bank"}, wr_bank, wb);
        check({tag, "_rd_bank"}, rd_bank, rb);
        check({tag, "_ready"}, frame_ready, rdy);
        check({tag, "_drops"}, drop_count, dc);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        mem_rdata = 12'hABC;
        tick();
        tick();
        rst = 1'b0;
        status("reset", 0, 1, 0, 0);
        check("reset_rd_valid", rd_valid, 0);
        check("reset_mem_en", mem_en, 0);

        // Read before any frame is ready returns zero.
        drive(1, 5, 0, 0, 0, 0, 0);
        #1 check("r029_ack", rd_ack, 1);
        tick();
        idle(2);
        check("r029_valid", rd_valid, 1);
        check("r029_data", rd_data, 0);

        // Frame handoff then a real read.
        drive(0, 0, 0, 0, 0, 1, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 1); tick();
        status("r030", 1, 0, 1, 0);
        drive(1, 10, 0, 0, 0, 0, 0); tick();
        check("r030_mem_en", mem_en, 1);
        check("r030_mem_addr", mem_addr, 18'd10);
        idle(2);
        check("r030_valid", rd_valid, 1);
        check("r030_data", rd_data, 12'hABC);

        drive(0, 0, 1, 20, 12'h123, 0, 0); tick();
        check("wr_mem_addr", mem_addr, 18'h20014);
        check("wr_mem_we", mem_we, 1);
        check("wr_mem_wdata", mem_wdata, 12'h123);
        idle(1);

        // Continuous contention: write wins every fifth cycle.
        for (int k = 1; k <= 12; k++) begin
            drive(1, k, 1, 100 + k, k, 0, 0);
            #1;
            check("r031_wr_ack", wr_ack, (k == 5 || k == 10));
            check("r031_rd_ack", rd_ack, !(k == 5 || k == 10));
            tick();
        end
        idle(3);

        drive(0, 0, 1, FSZ, 12'h555, 0, 0);
        #1 check("r033_wr_ack", wr_ack, 1);
        tick();
        check("r033_mem_en", mem_en, 0);
        drive(1, FSZ, 0, 0, 0, 0, 0); tick();
        idle(2);
        check("r033_valid", rd_valid, 1);
        check("r033_data", rd_data, 0);
        drive(1, FSZ - 1, 0, 0, 0, 0, 0); tick();
        idle(2);
        check("last_px_data", rd_data, 12'hABC);

        // Mixed traffic with a frame swap and varying memory data.
        for (int i = 0; i < 40; i++) begin
            mem_rdata = PB'(i * 11 + 3);
            drive(i % 3 != 0, i * 37, i % 4 < 2, i * 53, i * 5 + 1, i == 10, i == 13);
            tick();
        end
        idle(4);
        status("mixed", 0, 1, 1, 0);

        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 1, 0); tick();
        end
        status("r032", 0, 1, 1, 2);
        drive(0, 0, 0, 0, 0, 0, 1); tick();
        status("r032_swap", 1, 0, 1, 2);

        drive(0, 0, 0, 0, 0, 1, 0); tick();
        drive(0, 0, 0, 0, 0, 1, 1); tick();
        status("r022", 0, 1, 1, 3);
        drive(0, 0, 0, 0, 0, 1, 1); tick();
        status("r023", 0, 1, 1, 3);
        drive(0, 0, 0, 0, 0, 0, 1); tick();
        status("r023_swap", 1, 0, 1, 3);

        drive(0, 0, 0, 0, 0, 1, 0); tick();
        for (int i = 0; i < 260; i++) begin
            drive(0, 0, 0, 0, 0, 1, 0); tick();
        end
        check("drop_sat", drop_count, 255);
        drive(0, 0, 0, 0, 0, 0, 1); tick();
        idle(1);

        // Reset one cycle after a read grant cancels it.
        drive(1, 33, 0, 0, 0, 0, 0); tick();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        status("r034", 0, 1, 0, 0);
        check("r034_mem_en", mem_en, 0);
        check("r034_rd_valid", rd_valid, 0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("r034_no_valid", rd_valid, 0);
            tick();
        end
        check("r034_rd_data", rd_data, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
